// File: rtl/pulse_gen.sv
// Step/direction pulse generator for six one-hot selected motors.
// Each accepted command gives a DIR setup delay, then PulseNum STEP pulses.
module pulse_gen #(
    parameter int DATA_WIDTH  = 10,
    parameter int HALF_PERIOD = 2500,
    parameter int DIR_SETUP   = 50
) (
    input  logic                  sysclk,
    input  logic                  INIT,
    input  logic                  Start,
    input  logic [5:0]            i_Motor,
    input  logic [DATA_WIDTH-1:0] PulseNum,
    input  logic [5:0]            DRSign,
    output logic [5:0]            STEP,
    output logic [5:0]            DIR,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Err
);

    localparam int PMAX = (HALF_PERIOD > DIR_SETUP) ? HALF_PERIOD : DIR_SETUP;
    localparam int PW   = $clog2(PMAX + 1);

    localparam logic [PW-1:0] HP_LD = PW'(HALF_PERIOD - 1);
    localparam logic [PW-1:0] DS_LD = PW'(DIR_SETUP - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW
    } state_t;

    state_t                state, state_nxt;
    logic [PW-1:0]         phase, phase_nxt;
    logic [DATA_WIDTH-1:0] remain, remain_nxt;
    logic [5:0]            motor, motor_nxt;
    logic [5:0]            dir_nxt;
    logic [5:0]            step_nxt;
    logic                  busy_nxt;
    logic                  done_nxt;
    logic                  err_nxt;
    logic                  valid;

    always_ff @(posedge sysclk or posedge INIT) begin
        if (INIT) begin
            state  <= IDLE;
            phase  <= '0;
            remain <= '0;
            motor  <= '0;
            DIR    <= '0;
            STEP   <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            phase  <= phase_nxt;
            remain <= remain_nxt;
            motor  <= motor_nxt;
            DIR    <= dir_nxt;
            STEP   <= step_nxt;
            Busy   <= busy_nxt;
            Done   <= done_nxt;
            Err    <= err_nxt;
        end
    end

    // A command needs a non-zero count and exactly one motor bit.
    assign valid = (PulseNum != '0) && (i_Motor != 6'd0) &&
                   ((i_Motor & (i_Motor - 6'd1)) == 6'd0);

    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        remain_nxt = remain;
        motor_nxt  = motor;
        dir_nxt    = DIR;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                if (Start) begin
                    if (valid) begin
                        state_nxt  = SETUP;
                        phase_nxt  = DS_LD;
                        remain_nxt = PulseNum;
                        motor_nxt  = i_Motor;
                        dir_nxt    = DRSign;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (phase == '0) begin
                    state_nxt = HIGH;
                    phase_nxt = HP_LD;
                end else begin
                    phase_nxt = phase - 1'b1;
                end
            end
            HIGH: begin
                if (phase == '0) begin
                    state_nxt = LOW;
                    phase_nxt = HP_LD;
                end else begin
                    phase_nxt = phase - 1'b1;
                end
            end
            LOW: begin
                if (phase == '0) begin
                    remain_nxt = remain - 1'b1;
                    if (remain == DATA_WIDTH'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = HIGH;
                        phase_nxt = HP_LD;
                    end
                end else begin
                    phase_nxt = phase - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered from the next state so they track it exactly.
        busy_nxt = (state_nxt != IDLE);
        step_nxt = (state_nxt == HIGH) ? motor_nxt : 6'd0;
    end

endmodule
